// File: rtl/cfa_blend_pipe.sv
// ---------------------------------------------------------------------------
// cfa_blend_pipe
// Blends the smooth-direction and flat-direction interpolated pixels of the
// CFA demosaic path using the Q0.8 weights produced by w_intrp_s_f:
//   pix_out = sat((w_s*pix_s + w_f*pix_f + 2^(W_W-1)) >> W_W)
// The pipeline has three stages with valid/ready handshakes on both sides.
// A beat with both weights zero passes pix_f through unchanged.
// The weights are not renormalised.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat present
//   in_ready   block accepts the input beat this cycle
//   pix_s      smooth-direction pixel (PIX_W, unsigned)
//   pix_f      flat-direction pixel (PIX_W, unsigned)
//   w_s        smooth weight (W_W, Q0.8)
//   w_f        flat weight (W_W, Q0.8)
//   out_valid  output beat present
//   out_ready  downstream accepts the output beat
//   pix_out    blended pixel
//   sat        this beat was clipped to 2^PIX_W-1
//   zero_w     this beat had w_s==w_f==0; pix_f passed through
// ---------------------------------------------------------------------------
module cfa_blend_pipe #(
    parameter int PIX_W = 12,
    parameter int W_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pix_s,
    input  logic [PIX_W-1:0] pix_f,
    input  logic [W_W-1:0]   w_s,
    input  logic [W_W-1:0]   w_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix_out,
    output logic             sat,
    output logic             zero_w
);

    localparam int PROD_W = PIX_W + W_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (W_W - 1);

    logic              v1, v2, v3;
    logic              adv1, adv2, adv3;

    logic [PROD_W-1:0] p_s1, p_f1;
    logic              zero1;
    logic [PIX_W-1:0]  pixf1;

    logic [SUM_W-1:0]  sum2;
    logic              zero2;
    logic [PIX_W-1:0]  pixf2;

    // Rounded quotient; one extra MSB flags results beyond the pixel range.
    logic [PIX_W:0]    quo2;

    // Each stage advances when it is empty or its successor advances,
    // so bubbles collapse and a full pipe shifts as a whole.
    always_comb begin
        adv3 = out_ready | ~v3;
        adv2 = ~v2 | adv3;
        adv1 = ~v1 | adv2;
    end

    assign in_ready  = adv1;
    assign out_valid = v3;

    // S1: weighted products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            p_s1  <= '0;
            p_f1  <= '0;
            zero1 <= 1'b0;
            pixf1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p_s1  <= PROD_W'(w_s) * PROD_W'(pix_s);
                p_f1  <= PROD_W'(w_f) * PROD_W'(pix_f);
                zero1 <= (w_s == '0) && (w_f == '0);
                pixf1 <= pix_f;
            end
        end
    end

    // S2: rounded sum, one bit wider than the products so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            sum2  <= '0;
            zero2 <= 1'b0;
            pixf2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sum2  <= SUM_W'(p_s1) + SUM_W'(p_f1) + RND;
                zero2 <= zero1;
                pixf2 <= pixf1;
            end
        end
    end

    assign quo2 = (PIX_W + 1)'(sum2 >> W_W);

    // S3: clip or pass-through; holds while stalled because adv3 is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3      <= 1'b0;
            pix_out <= '0;
            sat     <= 1'b0;
            zero_w  <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                if (zero2) begin
                    pix_out <= pixf2;
                    sat     <= 1'b0;
                    zero_w  <= 1'b1;
                end else if (quo2[PIX_W]) begin
                    pix_out <= '1;
                    sat     <= 1'b1;
                    zero_w  <= 1'b0;
                end else begin
                    pix_out <= quo2[PIX_W-1:0];
                    sat     <= 1'b0;
                    zero_w  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfa_blend_pipe.sv
// ---------------------------------------------------------------------------
// tb_cfa_blend_pipe
// Testbench for cfa_blend_pipe. It drives directed and $urandom beats, keeps
// a queue of expected outputs and checks every output cycle against the
// head of that queue. It also checks latency, backpressure and reset.
// ---------------------------------------------------------------------------
module tb_cfa_blend_pipe;

    typedef struct {
        logic [11:0] pix;
        logic        sat;
        logic        zw;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pix_s;
    logic [11:0] pix_f;
    logic [7:0]  w_s;
    logic [7:0]  w_f;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] pix_out;
    logic        sat;
    logic        zero_w;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic hold_prev = 1'b0;
    logic lat_en    = 1'b0;
    exp_t exp_q[$];

    cfa_blend_pipe #(.PIX_W(12), .W_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_s     (pix_s),
        .pix_f     (pix_f),
        .w_s       (w_s),
        .w_f       (w_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix_out   (pix_out),
        .sat       (sat),
        .zero_w    (zero_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference blend in plain integer arithmetic.
    function automatic exp_t model(input int ps, input int pf, input int ws, input int wf);
        exp_t r;
        int   q;
        r.cyc = 0;
        if (ws == 0 && wf == 0) begin
            r.pix = 12'(pf);
            r.sat = 1'b0;
            r.zw  = 1'b1;
        end else begin
            q    = (ws * ps + wf * pf + 128) / 256;
            r.zw = 1'b0;
            if (q > 4095) begin
                r.pix = 12'd4095;
                r.sat = 1'b1;
            end else begin
                r.pix = 12'(q);
                r.sat = 1'b0;
            end
        end
        return r;
    endfunction

    // One clock cycle. Inputs are driven on the falling edge and the outputs
    // are checked 1 time unit later, well away from the active edge.
    task automatic step(input logic iv, input int ps, input int pf, input int ws, input int wf,
                        input logic ordy, input logic use_e, input exp_t e, output logic acc);
        exp_t front;
        exp_t nw;
        @(negedge clk);
        in_valid  = iv;
        pix_s     = 12'(ps);
        pix_f     = 12'(pf);
        w_s       = 8'(ws);
        w_f       = 8'(wf);
        out_ready = ordy;
        #1;
        if (hold_prev) check_eq("hold_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                front = exp_q[0];
                check_eq("pix_out", 32'(pix_out), 32'(front.pix));
                check_eq("sat", 32'(sat), 32'(front.sat));
                check_eq("zero_w", 32'(zero_w), 32'(front.zw));
                if (out_ready) begin
                    if (lat_en) check_eq("latency", 32'(cyc - front.cyc), 32'd3);
                    void'(exp_q.pop_front());
                end
            end
        end
        hold_prev = out_valid && !out_ready;
        acc = iv && in_ready;
        if (acc) begin
            nw     = use_e ? e : model(ps, pf, ws, wf);
            nw.cyc = cyc;
            exp_q.push_back(nw);
        end
    endtask

    task automatic drain();
        exp_t d;
        logic a;
        d = '{pix: 12'd0, sat: 1'b0, zw: 1'b0, cyc: 0};
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, d, a);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic dir_beat(input int ps, input int pf, input int ws, input int wf,
                            input int epix, input logic esat, input logic ezw);
        exp_t e;
        logic a;
        e = '{pix: 12'(epix), sat: esat, zw: ezw, cyc: 0};
        step(1'b1, ps, pf, ws, wf, 1'b1, 1'b1, e, a);
        check_eq("dir_accept", 32'(a), 32'd1);
    endtask

    initial begin
        exp_t d;
        logic a;
        int   sent;
        int   ps, pf, ws, wf, r;
        d = '{pix: 12'd0, sat: 1'b0, zw: 1'b0, cyc: 0};

        in_valid = 1'b0; out_ready = 1'b0;
        pix_s = '0; pix_f = '0; w_s = '0; w_f = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pix_out", 32'(pix_out), 32'd0);
        check_eq("rst_sat", 32'(sat), 32'd0);
        check_eq("rst_zero_w", 32'(zero_w), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed beats back to back with latency checked
        lat_en = 1'b1;
        dir_beat(1000, 2000, 128, 128, 1500, 1'b0, 1'b0);
        dir_beat(1, 0, 128, 0, 1, 1'b0, 1'b0);
        dir_beat(1, 0, 127, 0, 0, 1'b0, 1'b0);
        dir_beat(4095, 4095, 255, 255, 4095, 1'b1, 1'b0);
        dir_beat(3000, 777, 0, 0, 777, 1'b0, 1'b1);
        dir_beat(4095, 4095, 128, 128, 4095, 1'b0, 1'b0);
        dir_beat(4095, 0, 255, 0, 4079, 1'b0, 1'b0);
        drain();

        // Backpressure: 10 beats, out_ready low for cycles 4..9
        lat_en = 1'b0;
        sent = 0;
        for (int t = 0; t < 40 && sent < 10; t++) begin
            step(1'b1, 100 * sent + 7, 50 * sent + 3, 200, 56, !(t >= 4 && t <= 9), 1'b0, d, a);
            if (a) sent++;
            if (t >= 4 && t <= 9) check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check_eq("bp_sent", 32'(sent), 32'd10);
        drain();

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) step(1'b1, 900 + k, 400, 100, 150, 1'b1, 1'b0, d, a);
        @(posedge clk);
        #2;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_pix_out", 32'(pix_out), 32'd0);
        exp_q.delete();
        hold_prev = 1'b0;
        in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        lat_en = 1'b1;
        step(1'b1, 2000, 1000, 64, 192, 1'b1, 1'b0, d, a);
        check_eq("post_rst_accept", 32'(a), 32'd1);
        drain();

        // Random traffic with random stalls
        lat_en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 7));
            ps = int'($urandom_range(0, 4095));
            pf = int'($urandom_range(0, 4095));
            ws = int'($urandom_range(0, 255));
            wf = int'($urandom_range(0, 255));
            if (r == 0) begin
                ws = 0; wf = 0;
            end else if (r == 1) begin
                ps = int'($urandom_range(3800, 4095));
                pf = int'($urandom_range(3800, 4095));
                ws = int'($urandom_range(200, 255));
                wf = int'($urandom_range(200, 255));
            end
            step(($urandom % 4) != 0, ps, pf, ws, wf, ($urandom % 3) != 0, 1'b0, d, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule
